cpu_bus_memory: RTL and testbench
=================================

CPU_BUS_MEMORY -- requirements
Module: cpu_bus_memory

Interface
REQ-001 Parameter ADDR_W, default 16: CPU address width.
REQ-002 Parameter DATA_W, default 8: data width.
REQ-003 Parameter MEM_AW, default 10: implemented RAM address bits, giving 2^MEM_AW words.
REQ-004 Parameter RAM_BASE, default 0: first RAM address.
REQ-005 Parameter RESET_VECTOR, default 16'hCCDD: value returned at the vector pair.
REQ-006 Parameter WAIT_W, default 3: wait-state count width.
REQ-007 Ports, in order:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  CPU address.
- bus_enable  in  1  CPU requests an access this cycle.
- read_not_write  in  1  1 = read, 0 = write.
- data_in  in  DATA_W  write data from the CPU.
- data_out  out  DATA_W  read data to the CPU.
- ready  out  1  registered; 0 stalls the CPU.
- wait_cycles  in  WAIT_W  wait states per access.
- wp_enable  in  1  write-protect RAM words below wp_limit.
- wp_limit  in  ADDR_W  write-protect bound.
- load_en, load_addr[MEM_AW], load_data[DATA_W]  in  preload port.
- fault  out  1  one-cycle pulse on a rejected access.
- access_count  out  16  completed accesses, saturating.

Function
REQ-008 States are IDLE and WAIT.
REQ-009 A request is a rising edge with state == IDLE and bus_enable == 1; address, read_not_write and data_in are latched at that edge.
REQ-010 If wait_cycles == 0 at the request edge:
- the access completes at that edge;
- state stays IDLE and ready stays 1.
REQ-011 If wait_cycles == N > 0 at the request edge:
- state goes to WAIT, the counter loads N, and ready goes to 0;
- each WAIT edge decrements the counter;
- at the edge where the counter == 1, the access completes, state goes to IDLE and ready goes to 1.
- Net effect: ready is low for exactly N cycles.
REQ-012 Changes to wait_cycles during WAIT have no effect on the current access.
REQ-013 Decode, in priority order:
- address ADDR_W'hFFFC/FFFD returns RESET_VECTOR low/high byte;
- address in [RAM_BASE, RAM_BASE + 2^MEM_AW) hits RAM at offset address - RAM_BASE;
- otherwise the address is unmapped.
REQ-014 A read completion registers the decoded value into data_out. An unmapped read holds the previous data_out and pulses fault.
REQ-015 A write completion stores data_in to RAM only if the address is RAM and not (wp_enable && address < wp_limit).
REQ-016 Writes to vector, unmapped or protected addresses leave memory unchanged and pulse fault for one cycle.
REQ-017 data_out is unchanged on any write completion.
REQ-018 access_count increments on every completion, including faulting ones, and saturates at 16'hFFFF.
REQ-019 load_en is honoured only when state == IDLE and bus_enable == 0; it writes load_data to RAM[load_addr], ignores wp_enable, and does not change access_count.
REQ-020 load_en asserted while state == WAIT or bus_enable == 1 is dropped and pulses fault.
REQ-021 Addresses at the top RAM word and RAM_BASE + 2^MEM_AW: offset arithmetic is done at ADDR_W bits with no wrap; the top RAM word is RAM, and RAM_BASE + 2^MEM_AW is unmapped.

Reset
REQ-022 While rst = 1:
- state = IDLE, ready = 1, data_out = 0, fault = 0, access_count = 0, counter = 0.
REQ-023 Reset asserted during WAIT abandons the access: no write is committed and access_count is not incremented.
REQ-024 RAM contents are not reset.

Structure
REQ-025 Package cpu_bus_mem_pkg holds:
- the state enum (IDLE, WAIT);
- the vector address constants 'hFFFC/'hFFFD;
- the access_count width constant.
REQ-026 One sub-module, cpu_bus_mem_array: single-port, synchronous-write, synchronous-read storage of 2^MEM_AW x DATA_W words.
REQ-027 The port of cpu_bus_mem_array is shared by the CPU and preload paths under the mux rule of REQ-019.

Verification
REQ-028 Reset, wait_cycles = 0, read 'hFFFC then 'hFFFD -> data_out 'hDD then 'hCC; ready is 1 throughout; access_count = 2.
REQ-029 Preload RAM[99] = 'h73, wait_cycles = 3, read 'h0099 -> ready is 0 for exactly 3 cycles; data_out = 'h73 at the edge where ready returns to 1.
REQ-030 wp_enable = 1, wp_limit = 'h0100, write 'hAA to 'h0050 -> fault pulses 1 cycle; a read of 'h0050 returns its old value. With wp_enable = 0, the same write sticks.
REQ-031 Write to 'hFFFC and a read of unmapped 'h8000 -> fault pulses each time; data_out holds its prior value; access_count increments both times.
REQ-032 wait_cycles = 5, assert rst on the 2nd WAIT cycle of a write -> ready = 1 and state IDLE immediately; target word unchanged; access_count = 0.
REQ-033 load_en with bus_enable = 1 -> load dropped and fault pulses; access_count saturates at 'hFFFF after forced long run.

Source files
------------

// File: rtl/cpu_bus_mem_pkg.sv
// Shared types and constants for the CPU bus memory block.
package cpu_bus_mem_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  typedef enum logic [1:0] {
    DEC_VEC_LO   = 2'd0,
    DEC_VEC_HI   = 2'd1,
    DEC_RAM      = 2'd2,
    DEC_UNMAPPED = 2'd3
  } dec_e;

  localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
  localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
  localparam int          CNT_W       = 16;

endpackage

// File: rtl/cpu_bus_mem_array.sv
// Single-port RAM with synchronous write and enabled synchronous read; contents are never reset.
module cpu_bus_mem_array
  import cpu_bus_mem_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [DATA_W-1:0] rdata_q;

  // Read register only moves on an enabled read, so it doubles as the held read result.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_memory.sv
// CPU-facing memory: reset-vector ROM pair, RAM window with write protect, wait states and preload port.
module cpu_bus_memory
  import cpu_bus_mem_pkg::*;
#(
  parameter int                      ADDR_W       = 16,
  parameter int                      DATA_W       = 8,
  parameter int                      MEM_AW       = 10,
  parameter logic [ADDR_W-1:0]       RAM_BASE     = '0,
  parameter logic [2*DATA_W-1:0]     RESET_VECTOR = 16'hCCDD,
  parameter int                      WAIT_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              bus_enable,
  input  logic              read_not_write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  input  logic [WAIT_W-1:0] wait_cycles,
  input  logic              wp_enable,
  input  logic [ADDR_W-1:0] wp_limit,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              fault,
  output logic [CNT_W-1:0]  access_count
);

  localparam logic [ADDR_W:0] RAM_WORDS = (ADDR_W+1)'(1) << MEM_AW;

  state_e              state_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic                ready_q;
  logic                fault_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   vec_q;
  logic                sel_ram_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rnw_q;
  logic [DATA_W-1:0]   din_q;

  logic                req;
  logic                cpl_now;
  logic                cpl_wait;
  logic                cpl;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_rnw;
  logic [DATA_W-1:0]   cur_din;
  logic [ADDR_W:0]     off_w;
  dec_e                dec;
  logic                prot;
  logic                load_ok;
  logic                load_drop;
  logic                ram_we;
  logic                ram_re;
  logic                fault_d;
  logic                arr_we;
  logic [MEM_AW-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  // A zero-wait access completes on its request edge, so it decodes the live bus; a waited one uses the latch.
  always_comb begin
    req      = (state_q == IDLE) && bus_enable;
    cpl_now  = req && (wait_cycles == '0);
    cpl_wait = (state_q == WAIT) && (cnt_q == WAIT_W'(1));
    cpl      = (cpl_now || cpl_wait) && !rst;
    cur_addr = cpl_now ? address        : addr_q;
    cur_rnw  = cpl_now ? read_not_write : rnw_q;
    cur_din  = cpl_now ? data_in        : din_q;
    off_w    = {1'b0, cur_addr} - {1'b0, RAM_BASE};
    dec      = DEC_UNMAPPED;
    if (cur_addr == ADDR_W'(VEC_LO_ADDR))                   dec = DEC_VEC_LO;
    else if (cur_addr == ADDR_W'(VEC_HI_ADDR))              dec = DEC_VEC_HI;
    else if (cur_addr >= RAM_BASE && off_w < RAM_WORDS)     dec = DEC_RAM;
    prot      = wp_enable && (cur_addr < wp_limit);
    load_ok   = load_en && (state_q == IDLE) && !bus_enable && !rst;
    load_drop = load_en && !((state_q == IDLE) && !bus_enable);
    ram_we    = cpl && !cur_rnw && (dec == DEC_RAM) && !prot;
    ram_re    = cpl && cur_rnw && (dec == DEC_RAM);
    fault_d   = load_drop ||
                (cpl && (cur_rnw ? (dec == DEC_UNMAPPED) : ((dec != DEC_RAM) || prot)));
    arr_we    = ram_we || load_ok;
    arr_addr  = load_ok ? load_addr : off_w[MEM_AW-1:0];
    arr_wdata = load_ok ? load_data : cur_din;
  end

  cpu_bus_mem_array #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .re_i    (ram_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      fault_q   <= 1'b0;
      count_q   <= '0;
      vec_q     <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
      if (cpl && (count_q != '1)) count_q <= count_q + CNT_W'(1);
      if (cpl && cur_rnw) begin
        if (dec == DEC_VEC_LO) begin
          vec_q     <= RESET_VECTOR[DATA_W-1:0];
          sel_ram_q <= 1'b0;
        end else if (dec == DEC_VEC_HI) begin
          vec_q     <= RESET_VECTOR[2*DATA_W-1:DATA_W];
          sel_ram_q <= 1'b0;
        end else if (dec == DEC_RAM) begin
          sel_ram_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (req && (wait_cycles != '0)) begin
            state_q <= WAIT;
            cnt_q   <= wait_cycles;
            ready_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request operands are datapath only; they need no reset.
  always_ff @(posedge clk) begin
    if (req) begin
      addr_q <= address;
      rnw_q  <= read_not_write;
      din_q  <= data_in;
    end
  end

  assign data_out     = sel_ram_q ? arr_rdata : vec_q;
  assign ready        = ready_q;
  assign fault        = fault_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Directed bench for cpu_bus_memory with hand-computed expectations.
module tb_cpu_bus_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic        bus_enable;
  logic        read_not_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ready;
  logic [2:0]  wait_cycles;
  logic        wp_enable;
  logic [15:0] wp_limit;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic        fault;
  logic [15:0] access_count;

  int n_chk = 0;
  int n_err = 0;

  cpu_bus_memory dut (
    .clk            (clk),
    .rst            (rst),
    .address        (address),
    .bus_enable     (bus_enable),
    .read_not_write (read_not_write),
    .data_in        (data_in),
    .data_out       (data_out),
    .ready          (ready),
    .wait_cycles    (wait_cycles),
    .wp_enable      (wp_enable),
    .wp_limit       (wp_limit),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .fault          (fault),
    .access_count   (access_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    bus_enable = 1'b0;
    load_en    = 1'b1;
    load_addr  = a;
    load_data  = d;
    tick();
    load_en    = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input logic rnw, input logic [7:0] d);
    bus_enable     = 1'b1;
    address        = a;
    read_not_write = rnw;
    data_in        = d;
    tick();
  endtask

  initial begin
    int lowcnt;
    rst = 1'b1; address = '0; bus_enable = 1'b0; read_not_write = 1'b1; data_in = '0;
    wait_cycles = '0; wp_enable = 1'b0; wp_limit = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_data", data_out, 0);
    check("rst_fault", fault, 0);
    check("rst_count", access_count, 0);
    rst = 1'b0;
    tick();

    // Vector reads with no wait states
    access(16'hFFFC, 1'b1, 8'h00);
    check("vec_lo", data_out, 8'hDD);
    check("vec_lo_ready", ready, 1);
    access(16'hFFFD, 1'b1, 8'h00);
    check("vec_hi", data_out, 8'hCC);
    check("vec_hi_ready", ready, 1);
    bus_enable = 1'b0;
    tick();
    check("vec_count", access_count, 2);

    // Waited read of a preloaded word; wait_cycles changes mid-access
    preload(10'h099, 8'h73);
    wait_cycles = 3'd3;
    access(16'h0099, 1'b1, 8'h00);
    bus_enable  = 1'b0;
    wait_cycles = 3'd7;
    lowcnt = 0;
    for (int i = 0; i < 20 && !ready; i++) begin
      lowcnt++;
      tick();
    end
    check("wait_low_cycles", lowcnt, 3);
    check("wait_ready", ready, 1);
    check("wait_data", data_out, 8'h73);
    check("wait_count", access_count, 3);
    wait_cycles = 3'd0;

    // Write protection
    preload(10'h050, 8'h11);
    wp_enable = 1'b1; wp_limit = 16'h0100;
    access(16'h0050, 1'b0, 8'hAA);
    check("wp_fault", fault, 1);
    check("wp_data_hold", data_out, 8'h73);
    access(16'h0050, 1'b1, 8'h00);
    check("wp_fault_clear", fault, 0);
    check("wp_old_value", data_out, 8'h11);
    wp_enable = 1'b0;
    access(16'h0050, 1'b0, 8'hAA);
    check("nowp_fault", fault, 0);
    access(16'h0050, 1'b1, 8'h00);
    check("nowp_value", data_out, 8'hAA);
    check("nowp_count", access_count, 7);

    // RAM window edges
    access(16'h03FF, 1'b0, 8'h5A);
    check("top_wr_fault", fault, 0);
    access(16'h03FF, 1'b1, 8'h00);
    check("top_rd", data_out, 8'h5A);
    access(16'h0400, 1'b1, 8'h00);
    check("past_top_fault", fault, 1);
    check("past_top_hold", data_out, 8'h5A);

    // Vector write and unmapped read
    access(16'hFFFC, 1'b0, 8'h12);
    check("vecwr_fault", fault, 1);
    check("vecwr_hold", data_out, 8'h5A);
    access(16'h8000, 1'b1, 8'h00);
    check("unmap_fault", fault, 1);
    check("unmap_hold", data_out, 8'h5A);
    bus_enable = 1'b0;
    tick();
    check("fault_pulse_end", fault, 0);
    check("fault_count", access_count, 12);

    // Reset abandons a waited write
    access(16'h0060, 1'b0, 8'h22);
    wait_cycles = 3'd5;
    access(16'h0060, 1'b0, 8'h77);
    check("abort_ready_low", ready, 0);
    bus_enable = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1);
    check("abort_count", access_count, 0);
    check("abort_data", data_out, 0);
    tick();
    rst = 1'b0;
    wait_cycles = 3'd0;
    tick();
    access(16'h0060, 1'b1, 8'h00);
    check("abort_word", data_out, 8'h22);
    check("abort_count_after", access_count, 1);

    // Dropped preloads
    preload(10'h070, 8'h44);
    bus_enable = 1'b1; address = 16'hFFFC; read_not_write = 1'b1;
    load_en = 1'b1; load_addr = 10'h070; load_data = 8'h99;
    tick();
    load_en = 1'b0;
    check("load_busy_fault", fault, 1);
    check("load_busy_read", data_out, 8'hDD);
    access(16'h0070, 1'b1, 8'h00);
    check("load_dropped", data_out, 8'h44);
    wait_cycles = 3'd2;
    access(16'h0070, 1'b0, 8'h00);
    bus_enable = 1'b0;
    load_en = 1'b1; load_addr = 10'h070; load_data = 8'h99;
    tick();
    load_en = 1'b0;
    check("load_wait_fault", fault, 1);
    tick();
    check("load_wait_ready", ready, 1);
    wait_cycles = 3'd0;
    access(16'h0070, 1'b1, 8'h00);
    check("load_wait_dropped", data_out, 8'h00);
    check("load_count", access_count, 5);

    // Saturation of access_count
    bus_enable = 1'b1; address = 16'hFFFC; read_not_write = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("count_sat", access_count, 16'hFFFF);
    tick();
    check("count_sat_hold", access_count, 16'hFFFF);
    bus_enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
